fir_interp_seq: RTL and testbench

Parametrised sequencer for the L-fold interpolating FIR datapath: it generates the preload, coefficient-load, multiply and adder-tree pipeline strobes for each output sample. It owns the interpolation phase counter and a round-robin channel counter, where the previous generation relied on an external count. It sits between the input sample strobe and the tap shift register / MAC pipeline, and flags input overruns.

---
 rtl/fir_interp_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fir_interp_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_interp_seq.sv
// -----------------------------------------------------------------------------
// fir_interp_seq
//
// Sequencer for the L-fold interpolating FIR datapath. For every output sample
// it issues the tap-register preload, coefficient/data load, multiply and
// adder-tree strobes. It also owns the interpolation phase counter and a
// round-robin channel counter. Input samples that arrive while the sequencer
// cannot take them are flagged as overruns.
//
// Build option:
//   FIR_INTERP_OVERRUN_DET_EN  defined   -> sticky overrun detector present
//                              undefined -> overrun tied to 0, no register
//
// Parameters:
//   L            interpolation factor (output phases per input sample), >= 2
//   PH_W         phase counter width, >= clog2(L)
//   NCH          number of channels served round-robin, >= 1
//   CH_W         channel counter width, >= clog2(NCH)
//   LOAD_STAGES  register-load cycles (pre_load + sinc_en), >= 1
//   ADD_STAGES   adder-tree pipeline depth, >= 1
//
// Ports:
//   CLOCK       in   single clock, posedge
//   RESET       in   synchronous, active-high
//   Data_RDY    in   new input sample available (level)
//   shift_done  in   tap shift register finished advancing
//   loaded      in   output sample accepted downstream
//   pre_load    out  preload strobe to tap register
//   sinc_en     out  coefficient/data register load enable
//   mult_en     out  multiplier register load
//   sample_rdy  out  adder-tree output valid (last ADD cycle)
//   count_en    out  one-cycle phase-advance pulse
//   phase       out  current interpolation phase, 0..L-1
//   channel     out  current channel, 0..NCH-1
//   busy        out  high whenever the sequencer is not idle
//   overrun     out  sticky flag: Data_RDY seen while it could not be taken
// -----------------------------------------------------------------------------
module fir_interp_seq #(
    parameter int unsigned L           = 4,
    parameter int unsigned PH_W        = 2,
    parameter int unsigned NCH         = 1,
    parameter int unsigned CH_W        = 1,
    parameter int unsigned LOAD_STAGES = 2,
    parameter int unsigned ADD_STAGES  = 5
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            Data_RDY,
    input  logic            shift_done,
    input  logic            loaded,
    output logic            pre_load,
    output logic            sinc_en,
    output logic            mult_en,
    output logic            sample_rdy,
    output logic            count_en,
    output logic [PH_W-1:0] phase,
    output logic [CH_W-1:0] channel,
    output logic            busy,
    output logic            overrun
);

    // Stage counter must hold the longer of the two multi-cycle sequences.
    localparam int unsigned STG_MAX = (LOAD_STAGES > ADD_STAGES) ? LOAD_STAGES : ADD_STAGES;
    localparam int unsigned STG_W   = (STG_MAX > 1) ? $clog2(STG_MAX) : 1;

    localparam logic [STG_W-1:0] LOAD_LAST = STG_W'(LOAD_STAGES - 1);
    localparam logic [STG_W-1:0] ADD_LAST  = STG_W'(ADD_STAGES - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(L - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NCH - 1);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_PRELOAD      = 4'd1,
        S_LOAD_REG     = 4'd2,
        S_MULT         = 4'd3,
        S_ADD          = 4'd4,
        S_LOADED_WAIT  = 4'd5,
        S_INC          = 4'd6,
        S_SHIFT_WAIT   = 4'd7,
        S_PRE_LOAD_GEN = 4'd8
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [STG_W-1:0] r_stage;
    logic [STG_W-1:0] w_stage_nxt;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  w_phase_nxt;
    logic [CH_W-1:0]  r_channel;
    logic [CH_W-1:0]  w_channel_nxt;

    logic r_pre_load;
    logic r_sinc_en;
    logic r_mult_en;
    logic r_sample_rdy;
    logic r_count_en;
    logic r_busy;

    logic w_pre_load_nxt;
    logic w_sinc_en_nxt;
    logic w_mult_en_nxt;
    logic w_sample_rdy_nxt;
    logic w_count_en_nxt;
    logic w_busy_nxt;

    // Next-state, stage counter and phase/channel update.
    always_comb begin
        w_state_nxt   = r_state;
        w_stage_nxt   = '0;
        w_phase_nxt   = r_phase;
        w_channel_nxt = r_channel;

        case (r_state)
            S_IDLE: begin
                if (Data_RDY) begin
                    w_state_nxt = S_PRELOAD;
                end
            end
            S_PRELOAD: begin
                w_state_nxt = S_LOAD_REG;
            end
            S_LOAD_REG: begin
                if (r_stage == LOAD_LAST) begin
                    w_state_nxt = S_MULT;
                end else begin
                    w_stage_nxt = r_stage + STG_W'(1);
                end
            end
            S_MULT: begin
                w_state_nxt = S_ADD;
            end
            S_ADD: begin
                if (r_stage == ADD_LAST) begin
                    w_state_nxt = S_LOADED_WAIT;
                end else begin
                    w_stage_nxt = r_stage + STG_W'(1);
                end
            end
            S_LOADED_WAIT: begin
                if (loaded) begin
                    w_state_nxt = S_INC;
                end
            end
            S_INC: begin
                if (r_phase != PH_LAST) begin
                    w_phase_nxt = r_phase + PH_W'(1);
                    w_state_nxt = S_SHIFT_WAIT;
                end else if (r_channel != CH_LAST) begin
                    // Next channel reuses the current input sample: reload only.
                    w_phase_nxt   = '0;
                    w_channel_nxt = r_channel + CH_W'(1);
                    w_state_nxt   = S_LOAD_REG;
                end else begin
                    w_phase_nxt   = '0;
                    w_channel_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_SHIFT_WAIT: begin
                // A new sample takes precedence; shift_done is re-sampled afterwards.
                if (Data_RDY) begin
                    w_state_nxt = S_PRE_LOAD_GEN;
                end else if (shift_done) begin
                    w_state_nxt = S_MULT;
                end
            end
            S_PRE_LOAD_GEN: begin
                w_state_nxt = S_SHIFT_WAIT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered strobes line up
    // with the state they belong to.
    always_comb begin
        w_pre_load_nxt   = 1'b0;
        w_sinc_en_nxt    = 1'b0;
        w_mult_en_nxt    = 1'b0;
        w_sample_rdy_nxt = 1'b0;
        w_count_en_nxt   = 1'b0;
        w_busy_nxt       = (w_state_nxt != S_IDLE);

        case (w_state_nxt)
            S_PRELOAD: begin
                w_pre_load_nxt = 1'b1;
            end
            S_LOAD_REG: begin
                w_pre_load_nxt = 1'b1;
                w_sinc_en_nxt  = 1'b1;
            end
            S_MULT: begin
                w_mult_en_nxt = 1'b1;
            end
            S_ADD: begin
                w_sample_rdy_nxt = (w_stage_nxt == ADD_LAST);
            end
            S_INC: begin
                w_count_en_nxt = 1'b1;
            end
            S_PRE_LOAD_GEN: begin
                w_pre_load_nxt = 1'b1;
            end
            default: begin
                w_pre_load_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_stage      <= '0;
            r_phase      <= '0;
            r_channel    <= '0;
            r_pre_load   <= 1'b0;
            r_sinc_en    <= 1'b0;
            r_mult_en    <= 1'b0;
            r_sample_rdy <= 1'b0;
            r_count_en   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_stage      <= w_stage_nxt;
            r_phase      <= w_phase_nxt;
            r_channel    <= w_channel_nxt;
            r_pre_load   <= w_pre_load_nxt;
            r_sinc_en    <= w_sinc_en_nxt;
            r_mult_en    <= w_mult_en_nxt;
            r_sample_rdy <= w_sample_rdy_nxt;
            r_count_en   <= w_count_en_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

`ifdef FIR_INTERP_OVERRUN_DET_EN
    logic r_overrun;
    logic w_rdy_blocked;

    // Only IDLE and SHIFT_WAIT can accept a new sample.
    assign w_rdy_blocked = Data_RDY && (r_state != S_IDLE) && (r_state != S_SHIFT_WAIT);

    // Sticky until reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_overrun <= 1'b0;
        end else if (w_rdy_blocked) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

    assign pre_load   = r_pre_load;
    assign sinc_en    = r_sinc_en;
    assign mult_en    = r_mult_en;
    assign sample_rdy = r_sample_rdy;
    assign count_en   = r_count_en;
    assign phase      = r_phase;
    assign channel    = r_channel;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fir_interp_seq.sv
// -----------------------------------------------------------------------------
// tb_fir_interp_seq
//
// Three sequencer instances with different parameter sets run side by side:
//   dut 0: defaults (L=4, NCH=1, LOAD_STAGES=2, ADD_STAGES=5)
//   dut 1: L=2, NCH=2
//   dut 2: LOAD_STAGES=3, ADD_STAGES=2
// Stimulus is a directed per-cycle table. A procedural model walks each table
// through the operation rules and writes the expected outputs for every cycle;
// a few hand-derived values pin the model before simulation starts.
// -----------------------------------------------------------------------------
module tb_fir_interp_seq;

    localparam int NCYC = 140;
    localparam int ND   = 3;

`ifdef FIR_INTERP_OVERRUN_DET_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic CLOCK;
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic rst_v  [ND];
    logic drdy_v [ND];
    logic sd_v   [ND];
    logic ld_v   [ND];

    logic o_pl   [ND];
    logic o_se   [ND];
    logic o_me   [ND];
    logic o_sr   [ND];
    logic o_ce   [ND];
    logic o_busy [ND];
    logic o_ovr  [ND];
    logic o_ch   [ND];
    logic [1:0] ph_a;
    logic       ph_b;
    logic [1:0] ph_c;

    fir_interp_seq u_dut_a (
        .CLOCK(CLOCK), .RESET(rst_v[0]), .Data_RDY(drdy_v[0]), .shift_done(sd_v[0]),
        .loaded(ld_v[0]), .pre_load(o_pl[0]), .sinc_en(o_se[0]), .mult_en(o_me[0]),
        .sample_rdy(o_sr[0]), .count_en(o_ce[0]), .phase(ph_a), .channel(o_ch[0]),
        .busy(o_busy[0]), .overrun(o_ovr[0])
    );

    fir_interp_seq #(.L(2), .PH_W(1), .NCH(2), .CH_W(1)) u_dut_b (
        .CLOCK(CLOCK), .RESET(rst_v[1]), .Data_RDY(drdy_v[1]), .shift_done(sd_v[1]),
        .loaded(ld_v[1]), .pre_load(o_pl[1]), .sinc_en(o_se[1]), .mult_en(o_me[1]),
        .sample_rdy(o_sr[1]), .count_en(o_ce[1]), .phase(ph_b), .channel(o_ch[1]),
        .busy(o_busy[1]), .overrun(o_ovr[1])
    );

    fir_interp_seq #(.LOAD_STAGES(3), .ADD_STAGES(2)) u_dut_c (
        .CLOCK(CLOCK), .RESET(rst_v[2]), .Data_RDY(drdy_v[2]), .shift_done(sd_v[2]),
        .loaded(ld_v[2]), .pre_load(o_pl[2]), .sinc_en(o_se[2]), .mult_en(o_me[2]),
        .sample_rdy(o_sr[2]), .count_en(o_ce[2]), .phase(ph_c), .channel(o_ch[2]),
        .busy(o_busy[2]), .overrun(o_ovr[2])
    );

    // Stimulus tables: value driven during cycle c (sampled at the end of c).
    bit s_drdy [ND][NCYC];
    bit s_sd   [ND][NCYC];
    bit s_ld   [ND][NCYC];
    bit s_rst  [ND][NCYC];

    // Expected outputs during cycle c.
    bit e_pl   [ND][NCYC];
    bit e_se   [ND][NCYC];
    bit e_me   [ND][NCYC];
    bit e_sr   [ND][NCYC];
    bit e_ce   [ND][NCYC];
    bit e_busy [ND][NCYC];
    bit e_ovr  [ND][NCYC];
    int e_ph   [ND][NCYC];
    int e_ch   [ND][NCYC];

    int n_chk;
    int n_fail;

    // Model cursor: current cycle, phase, channel, first overrun cycle, reset hit.
    int w_t;
    int w_ph;
    int w_ch;
    int w_ovr;
    bit w_rh;

    // Record one cycle of model activity and advance the cursor.
    task automatic put(input int d, input bit idle, input bit pl, input bit se, input bit me,
                       input bit sr, input bit ce, input bit rdy_ok);
        if (w_rh || w_t >= NCYC) return;
        e_pl[d][w_t]   = pl;
        e_se[d][w_t]   = se;
        e_me[d][w_t]   = me;
        e_sr[d][w_t]   = sr;
        e_ce[d][w_t]   = ce;
        e_busy[d][w_t] = !idle;
        e_ph[d][w_t]   = w_ph;
        e_ch[d][w_t]   = w_ch;
        e_ovr[d][w_t]  = OVR_EN && (w_ovr <= w_t);
        if (s_rst[d][w_t]) begin
            w_rh  = 1'b1;
            w_ph  = 0;
            w_ch  = 0;
            w_ovr = NCYC;
        end else if (s_drdy[d][w_t] && !rdy_ok && (w_ovr > w_t + 1)) begin
            w_ovr = w_t + 1;
        end
        w_t++;
    endtask

    // Walk the stimulus table of one instance through the operating rules.
    task automatic walk(input int d, input int lp, input int np, input int ls, input int nadd);
        bit go;
        bit fin;
        bit more;
        w_t = 0; w_ph = 0; w_ch = 0; w_ovr = NCYC; w_rh = 1'b0;
        while (w_t < NCYC) begin
            w_rh = 1'b0;
            go   = 1'b0;
            while (!go && !w_rh && w_t < NCYC) begin
                go = s_drdy[d][w_t];
                put(d, 1, 0, 0, 0, 0, 0, 1);
            end
            if (!go || w_rh) continue;
            put(d, 0, 1, 0, 0, 0, 0, 0);                       // preload
            fin = 1'b0;
            while (!fin && !w_rh && w_t < NCYC) begin          // one channel
                for (int k = 0; k < ls; k++) put(d, 0, 1, 1, 0, 0, 0, 0);
                more = 1'b1;
                while (more && !w_rh && w_t < NCYC) begin      // one phase
                    put(d, 0, 0, 0, 1, 0, 0, 0);
                    for (int k = 0; k < nadd; k++) put(d, 0, 0, 0, 0, (k == nadd - 1), 0, 0);
                    go = 1'b0;
                    while (!go && !w_rh && w_t < NCYC) begin
                        go = s_ld[d][w_t];
                        put(d, 0, 0, 0, 0, 0, 0, 0);
                    end
                    put(d, 0, 0, 0, 0, 0, 1, 0);               // count_en
                    if (w_rh || w_t >= NCYC) break;
                    if (w_ph < lp - 1) begin
                        w_ph++;
                        go = 1'b0;
                        while (!go && !w_rh && w_t < NCYC) begin
                            if (s_drdy[d][w_t]) begin
                                put(d, 0, 0, 0, 0, 0, 0, 1);   // waiting
                                put(d, 0, 1, 0, 0, 0, 0, 0);   // preload pulse
                            end else begin
                                go = s_sd[d][w_t];
                                put(d, 0, 0, 0, 0, 0, 0, 1);
                            end
                        end
                    end else begin
                        w_ph = 0;
                        more = 1'b0;
                        if (w_ch < np - 1) begin
                            w_ch++;
                        end else begin
                            w_ch = 0;
                            fin  = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic lit(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: model gives %0d, hand value %0d", name, got, want);
        end
    endtask

    function automatic int sum_pl(input int d, input int a, input int b);
        int s = 0;
        for (int c = a; c <= b; c++) s += int'(e_pl[d][c]);
        return s;
    endfunction

    function automatic int sum_ce(input int d, input int a, input int b);
        int s = 0;
        for (int c = a; c <= b; c++) s += int'(e_ce[d][c]);
        return s;
    endfunction

    initial begin
        logic [6:0] got_f;
        logic [6:0] exp_f;
        logic [1:0] got_ph;
        logic       got_ch;
        n_chk  = 0;
        n_fail = 0;
        for (int d = 0; d < ND; d++) begin
            rst_v[d] = 1'b1; drdy_v[d] = 1'b0; sd_v[d] = 1'b0; ld_v[d] = 1'b0;
        end

        // dut 0: four-phase run, then SHIFT_WAIT collision, overrun, stall, reset in ADD.
        for (int c = 0; c < NCYC; c++) begin
            s_ld[0][c] = 1'b1; s_ld[1][c] = 1'b1; s_ld[2][c] = 1'b1;
        end
        s_drdy[0][2] = 1'b1;
        s_sd[0][15] = 1'b1; s_sd[0][25] = 1'b1; s_sd[0][35] = 1'b1;
        s_drdy[0][60] = 1'b1;
        s_drdy[0][73] = 1'b1;
        for (int c = 73; c <= 75; c++) s_sd[0][c] = 1'b1;
        s_drdy[0][78] = 1'b1;
        for (int c = 82; c <= 89; c++) s_ld[0][c] = 1'b0;
        s_sd[0][94]  = 1'b1;
        s_rst[0][98] = 1'b1;
        s_drdy[0][110] = 1'b1;
        // dut 1: two channels, two phases.
        s_drdy[1][2] = 1'b1;
        s_sd[1][15] = 1'b1; s_sd[1][35] = 1'b1;
        // dut 2: short adder tree, long load.
        s_drdy[2][0] = 1'b1;
        s_sd[2][11]  = 1'b1;

        walk(0, 4, 1, 2, 5);
        walk(1, 2, 2, 2, 5);
        walk(2, 4, 1, 3, 2);

        // Hand-derived anchors for the model.
        lit("a_first_sr_c11", int'(e_sr[0][11]), 1);
        lit("a_no_sr_c10", int'(e_sr[0][10]), 0);
        lit("a_sr_phases", e_ph[0][11] + 10 * e_ph[0][21] + 100 * e_ph[0][31] + 1000 * e_ph[0][41], 3210);
        lit("a_sr_c21_31_41", int'(e_sr[0][21]) + int'(e_sr[0][31]) + int'(e_sr[0][41]), 3);
        lit("a_count_en_c13", int'(e_ce[0][13]), 1);
        lit("a_phase_c12_c14", 10 * e_ph[0][12] + e_ph[0][14], 1);
        lit("a_busy_c43_c44", 10 * int'(e_busy[0][43]) + int'(e_busy[0][44]), 10);
        lit("a_pregen_c74", int'(e_pl[0][74]), 1);
        lit("a_mult_c75_c76", 10 * int'(e_me[0][75]) + int'(e_me[0][76]), 1);
        lit("a_overrun_c78_c79", 10 * int'(e_ovr[0][78]) + int'(e_ovr[0][79]), int'(OVR_EN));
        lit("a_stall_no_count_en", sum_ce(0, 82, 90), 0);
        lit("a_phase_c97", e_ph[0][97], 2);
        lit("a_after_reset_c99", int'(e_busy[0][99]) + int'(e_ovr[0][99]) + e_ph[0][99], 0);
        lit("a_sr_after_reset_c119", int'(e_sr[0][119]), 1);
        lit("b_chph_at_sr", 1000 * (2 * e_ch[1][11] + e_ph[1][11]) + 100 * (2 * e_ch[1][21] + e_ph[1][21])
                            + 10 * (2 * e_ch[1][31] + e_ph[1][31]) + (2 * e_ch[1][41] + e_ph[1][41]), 123);
        lit("b_sinc_ch1_c24_c25", int'(e_se[1][24]) + int'(e_se[1][25]) + e_ch[1][24], 3);
        lit("b_total_pre_load", sum_pl(1, 0, NCYC - 1), 5);
        lit("c_pre_load_c1_c4", sum_pl(2, 1, 4) + 10 * int'(e_pl[2][5]), 4);
        lit("c_sinc_c1_c4", 1000 * int'(e_se[2][1]) + 100 * int'(e_se[2][2]) + 10 * int'(e_se[2][3]) + int'(e_se[2][4]), 111);
        lit("c_mult_c5_sr_c7", 10 * int'(e_me[2][5]) + int'(e_sr[2][7]), 11);

        repeat (3) @(posedge CLOCK);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge CLOCK);
            #1;
            for (int d = 0; d < ND; d++) begin
                rst_v[d]  = s_rst[d][c];
                drdy_v[d] = s_drdy[d][c];
                sd_v[d]   = s_sd[d][c];
                ld_v[d]   = s_ld[d][c];
            end
            @(negedge CLOCK);
            for (int d = 0; d < ND; d++) begin
                got_f = {o_pl[d], o_se[d], o_me[d], o_sr[d], o_ce[d], o_busy[d], o_ovr[d]};
                exp_f = {e_pl[d][c], e_se[d][c], e_me[d][c], e_sr[d][c], e_ce[d][c], e_busy[d][c], e_ovr[d][c]};
                case (d)
                    0:       got_ph = ph_a;
                    1:       got_ph = {1'b0, ph_b};
                    default: got_ph = ph_c;
                endcase
                got_ch = o_ch[d];
                n_chk++;
                if (got_f !== exp_f || got_ph !== 2'(e_ph[d][c]) || got_ch !== 1'(e_ch[d][c])) begin
                    n_fail++;
                    $display("FAIL dut%0d cycle %0d pl/se/me/sr/ce/busy/ovr: got %b ph=%0d ch=%0d, expected %b ph=%0d ch=%0d",
                             d, c, got_f, got_ph, got_ch, exp_f, e_ph[d][c], e_ch[d][c]);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
